serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial adder sequencer that reuses a single 1-bit adder cell (two half-adder stages plus carry OR) to add or subtract two WIDTH-bit operands, one bit per clock, LSB first. It sits between a start/done control interface and the shared 1-bit adder datapath. It owns the operand shift registers, the carry flip-flop, the bit counter and the result register.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- clk_in  input  1  single clock; all state updates on rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- start_in  input  1  request an operation; sampled only in IDLE.
- sub_in  input  1  0 = a_in + b_in, 1 = a_in - b_in; captured with operands.
- a_in  input  WIDTH  operand A; captured on the accepted start.
- b_in  input  WIDTH  operand B; captured on the accepted start.
- busy_out  output  1  high while an operation is in flight (ADD and DONE states).
- done_out  output  1  one-cycle pulse when sum_out/carry_out are updated.
- sum_out  output  WIDTH  result register, low WIDTH bits.
- carry_out  output  1  carry out of MSB; for subtract, 1 = no borrow (A >= B unsigned).

## Operation
- States: IDLE, ADD, DONE. Reset state IDLE.
- IDLE: if start_in = 1, then on that edge:
  - capture a_in into shift register A;
  - capture b_in, or ~b_in when sub_in = 1, into shift register B;
  - set carry FF to sub_in;
  - clear the bit counter and partial-sum shift register;
  - go to ADD.
- If start_in = 0, remain in IDLE.
- ADD: each cycle the cell computes s = A[0] ^ B[0] ^ c and cout = (A[0]&B[0]) | (c&(A[0]^B[0])).
  - s shifts into the partial-sum MSB; partial sum shifts right.
  - A and B shift right by one.
  - carry FF <= cout.
  - Counter increments.
- After the ADD cycle with counter = WIDTH-1, go to DONE.
- DONE: sum_out <= partial sum, carry_out <= carry FF, done_out = 1 for this cycle only, then go to IDLE.
- start_in is ignored in ADD and DONE; there is no queuing. A start held high through DONE is accepted in the following IDLE cycle.
- sum_out and carry_out hold their last values until the next DONE; they never show partial results.
- Arithmetic is modulo 2^WIDTH. Operands are unsigned; signed interpretation is left to the consumer.
- The counter is $clog2(WIDTH) bits wide and wraps only through the DONE transition.

## Timing
- Reset values: busy_out 0, done_out 0, sum_out 0, carry_out 0, state IDLE, counter 0, all shift registers and carry FF 0.
- Start accepted at edge T0. busy_out is high from T0+1 through the DONE cycle.
- ADD occupies cycles T0+1 .. T0+WIDTH.
- done_out is high in cycle T0+WIDTH+1, and sum_out/carry_out are valid from that cycle.
- Latency start-to-done: WIDTH+1 cycles. Minimum start-to-start period: WIDTH+2 cycles.
- rst_in asserted mid-operation aborts immediately (asynchronous):
  - all outputs and state return to reset values;
  - no done_out pulse is produced for the aborted operation;
  - the first start after deassertion behaves normally.
- start_in asserted in the same cycle rst_in deasserts: not accepted unless rst_in is low at the sampling edge.

## Test plan
- WIDTH=8, add 8'h3C + 8'h05 -> done_out pulses exactly 9 cycles after start edge; sum_out = 8'h41, carry_out = 0; busy_out high 9 cycles.
- Add 8'hFF + 8'h01 -> sum_out = 8'h00, carry_out = 1. Then add 8'h00 + 8'h00 -> sum_out = 8'h00, carry_out = 0.
- Subtract 8'h10 - 8'h01 -> sum_out = 8'h0F, carry_out = 1. Subtract 8'h01 - 8'h02 -> sum_out = 8'hFF, carry_out = 0.
- Start held high continuously with 8'h01 + 8'h01 -> results every 10 cycles, done_out a single-cycle pulse each time. Operand changes while busy have no effect on the in-flight result.
- Pulse rst_in at cycle 4 of an ADD for 8'hAA + 8'h55 -> all outputs 0 immediately, no done_out. A subsequent 8'h12 + 8'h34 -> sum_out = 8'h46 after 9 cycles.
- Random sweep, 1000 operations, WIDTH=8 and WIDTH=16 -> {carry_out, sum_out} matches a reference add/subtract model; sum_out stable between done pulses.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract sequencer around one shared 1-bit
// full-adder cell. Operands are shifted out LSB first, one bit per clock. The
// result register only changes when an operation completes.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic             sub_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] aShift_q, aShift_d;
    logic [WIDTH-1:0] bShift_q, bShift_d;
    logic [WIDTH-1:0] partSum_q, partSum_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carryFf_q, carryFf_d;
    logic             resCarry_q, resCarry_d;
    logic [CW-1:0]    bitCnt_q, bitCnt_d;

    logic haSum, haCarry1, haCarry2, cellSum, cellCarry;

    // Shared 1-bit adder cell: two half-adder stages joined by a carry OR.
    always_comb begin
        haSum     = aShift_q[0] ^ bShift_q[0];
        haCarry1  = aShift_q[0] & bShift_q[0];
        cellSum   = haSum ^ carryFf_q;
        haCarry2  = haSum & carryFf_q;
        cellCarry = haCarry1 | haCarry2;
    end

    // Next-state logic. Subtraction is A + ~B + 1: B is inverted on capture
    // and the carry FF is seeded with 1. The result register is loaded on the
    // edge that ends the last ADD cycle, so it is already valid during the
    // DONE cycle in which done_out pulses.
    always_comb begin
        state_d    = state_q;
        aShift_d   = aShift_q;
        bShift_d   = bShift_q;
        partSum_d  = partSum_q;
        sum_d      = sum_q;
        carryFf_d  = carryFf_q;
        resCarry_d = resCarry_q;
        bitCnt_d   = bitCnt_q;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    aShift_d  = a_in;
                    bShift_d  = sub_in ? ~b_in : b_in;
                    carryFf_d = sub_in;
                    bitCnt_d  = '0;
                    partSum_d = '0;
                    state_d   = ADD;
                end
            end
            ADD: begin
                partSum_d = {cellSum, partSum_q[WIDTH-1:1]};
                aShift_d  = aShift_q >> 1;
                bShift_d  = bShift_q >> 1;
                carryFf_d = cellCarry;
                bitCnt_d  = bitCnt_q + 1'b1;
                if (bitCnt_q == LAST_BIT) begin
                    sum_d      = {cellSum, partSum_q[WIDTH-1:1]};
                    resCarry_d = cellCarry;
                    bitCnt_d   = '0;
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            aShift_q   <= '0;
            bShift_q   <= '0;
            partSum_q  <= '0;
            sum_q      <= '0;
            carryFf_q  <= 1'b0;
            resCarry_q <= 1'b0;
            bitCnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            aShift_q   <= aShift_d;
            bShift_q   <= bShift_d;
            partSum_q  <= partSum_d;
            sum_q      <= sum_d;
            carryFf_q  <= carryFf_d;
            resCarry_q <= resCarry_d;
            bitCnt_q   <= bitCnt_d;
        end
    end

    // Status flags come straight from the state; results from the registers.
    always_comb begin
        busy_out  = (state_q != IDLE);
        done_out  = (state_q == DONE);
        sum_out   = sum_q;
        carry_out = resCarry_q;
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl: one WIDTH=8 and one WIDTH=16 instance,
// directed vector table, hand-written corner sequences and a random sweep
// against an arithmetic reference model.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    logic rst;

    logic       start8, sub8, busy8, done8, carry8;
    logic [7:0] a8, b8, sum8;
    logic        start16, sub16, busy16, done16, carry16;
    logic [15:0] a16, b16, sum16;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       sub;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] expSum;
        logic       expCarry;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk_in(clk), .rst_in(rst), .start_in(start8), .sub_in(sub8),
        .a_in(a8), .b_in(b8), .busy_out(busy8), .done_out(done8),
        .sum_out(sum8), .carry_out(carry8)
    );

    serial_add_ctrl #(.WIDTH(16)) dut16 (
        .clk_in(clk), .rst_in(rst), .start_in(start16), .sub_in(sub16),
        .a_in(a16), .b_in(b16), .busy_out(busy16), .done_out(done16),
        .sum_out(sum16), .carry_out(carry16)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic st, input logic sb,
                                 input logic [31:0] a, input logic [31:0] b);
        if (idx == 0) begin
            start8 = st; sub8 = sb; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            start16 = st; sub16 = sb; a16 = a[15:0]; b16 = b[15:0];
        end
    endtask

    function automatic logic [31:0] getSum(input int idx);
        return (idx == 0) ? {24'd0, sum8} : {16'd0, sum16};
    endfunction
    function automatic logic getCarry(input int idx);
        return (idx == 0) ? carry8 : carry16;
    endfunction
    function automatic logic getDone(input int idx);
        return (idx == 0) ? done8 : done16;
    endfunction
    function automatic logic getBusy(input int idx);
        return (idx == 0) ? busy8 : busy16;
    endfunction

    // Reference: unsigned add/subtract modulo 2^w; subtract carry = no borrow.
    task automatic refModel(input int w, input logic sb, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] s, output logic c);
        longint unsigned modulus = longint'(1) << w;
        longint unsigned la = a, lb = b, full;
        if (!sb) begin
            full = la + lb;
            s = 32'(full % modulus);
            c = (full >= modulus);
        end else begin
            s = 32'((la + modulus - lb) % modulus);
            c = (la >= lb);
        end
    endtask

    // One operation from an idle DUT; operands are scrambled while busy.
    task automatic runOp(input int idx, input logic sb, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expSum, input logic expCarry);
        int w = (idx == 0) ? 8 : 16;
        logic [31:0] prevSum = getSum(idx);
        logic prevCarry = getCarry(idx);
        int doneAt = 0;
        int busyCnt = 0;
        int n = 1;
        logic stable = 1'b1;
        applyStimulus(idx, 1'b1, sb, a, b);
        @(posedge clk); #1;
        applyStimulus(idx, 1'b0, 1'($urandom), $urandom, $urandom);
        while (doneAt == 0 && n <= 60) begin
            if (getBusy(idx)) busyCnt++;
            if (getDone(idx)) doneAt = n;
            else begin
                if (getSum(idx) !== prevSum || getCarry(idx) !== prevCarry) stable = 1'b0;
                @(posedge clk); #1;
                n++;
            end
        end
        checkOutput("latency", doneAt, w + 1);
        checkOutput("busyCycles", busyCnt, w + 1);
        checkOutput("stableBeforeDone", {31'd0, stable}, 32'd1);
        checkOutput("sum", getSum(idx), expSum);
        checkOutput("carry", {31'd0, getCarry(idx)}, {31'd0, expCarry});
        @(posedge clk); #1;
        checkOutput("donePulseEnds", {31'd0, getDone(idx)}, 32'd0);
        checkOutput("idleAfterDone", {31'd0, getBusy(idx)}, 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rb, es;
        logic rs, ec;
        int dones, lastDone, firstDone;
        logic spacingOk, singleOk, prevDone;

        vecs[0] = '{1'b0, 8'h3C, 8'h05, 8'h41, 1'b0};
        vecs[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[2] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[3] = '{1'b1, 8'h10, 8'h01, 8'h0F, 1'b1};
        vecs[4] = '{1'b1, 8'h01, 8'h02, 8'hFF, 1'b0};
        vecs[5] = '{1'b0, 8'h12, 8'h34, 8'h46, 1'b0};
        vecs[6] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1};
        vecs[7] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b1};
        vecs[8] = '{1'b1, 8'hFF, 8'hFF, 8'h00, 1'b1};
        vecs[9] = '{1'b1, 8'h00, 8'h01, 8'hFF, 1'b0};

        rst = 1'b1;
        applyStimulus(0, 1'b0, 1'b0, 0, 0);
        applyStimulus(1, 1'b0, 1'b0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            checkOutput("resetBusy", {31'd0, getBusy(i)}, 32'd0);
            checkOutput("resetDone", {31'd0, getDone(i)}, 32'd0);
            checkOutput("resetSum", getSum(i), 32'd0);
            checkOutput("resetCarry", {31'd0, getCarry(i)}, 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vector table on the 8-bit instance
        for (int i = 0; i < 10; i++)
            runOp(0, vecs[i].sub, {24'd0, vecs[i].a}, {24'd0, vecs[i].b},
                  {24'd0, vecs[i].expSum}, vecs[i].expCarry);

        // Start held high: a result every WIDTH+2 cycles, single-cycle pulses
        applyStimulus(0, 1'b1, 1'b0, 32'h01, 32'h01);
        dones = 0; lastDone = 0; firstDone = 0;
        spacingOk = 1'b1; singleOk = 1'b1; prevDone = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); #1;
            if (done8) begin
                if (prevDone) singleOk = 1'b0;
                if (dones == 0) firstDone = n;
                else if (n - lastDone != 10) spacingOk = 1'b0;
                lastDone = n;
                dones++;
                checkOutput("heldSum", {24'd0, sum8}, 32'h02);
                checkOutput("heldCarry", {31'd0, carry8}, 32'd0);
            end
            prevDone = done8;
        end
        applyStimulus(0, 1'b0, 1'b0, 0, 0);
        checkOutput("heldDoneCount", dones, 3);
        checkOutput("heldFirstDone", firstDone, 9);
        checkOutput("heldSpacing", {31'd0, spacingOk}, 32'd1);
        checkOutput("heldSinglePulse", {31'd0, singleOk}, 32'd1);
        @(posedge clk); #1;

        // Asynchronous reset in the fourth ADD cycle aborts the operation
        applyStimulus(0, 1'b1, 1'b0, 32'hAA, 32'h55);
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 1'b0, 0, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("abortBusy", {31'd0, busy8}, 32'd0);
        checkOutput("abortDone", {31'd0, done8}, 32'd0);
        checkOutput("abortSum", {24'd0, sum8}, 32'd0);
        checkOutput("abortCarry", {31'd0, carry8}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        dones = 0;
        for (int n = 0; n < 14; n++) begin
            @(posedge clk); #1;
            if (done8) dones++;
        end
        checkOutput("abortNoDone", dones, 0);
        runOp(0, 1'b0, 32'h12, 32'h34, 32'h46, 1'b0);

        // Random sweep on both widths against the reference model
        for (int idx = 0; idx < 2; idx++) begin
            for (int k = 0; k < 1000; k++) begin
                ra = (idx == 0) ? ($urandom & 32'hFF) : ($urandom & 32'hFFFF);
                rb = (idx == 0) ? ($urandom & 32'hFF) : ($urandom & 32'hFFFF);
                rs = 1'($urandom);
                refModel((idx == 0) ? 8 : 16, rs, ra, rb, es, ec);
                runOp(idx, rs, ra, rb, es, ec);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
